seg7_scan_driver: RTL and testbench

- Hardware scanner for the 4-digit common-anode 7-segment display.
- Sits downstream of the memory-mapped peripheral block and consumes a 16-bit hex value, per-digit decimal points and a blank mask.
- Produces the 12-bit display bus {anodes[3:0], segments[7:0]} autonomously, so software no longer time-multiplexes digits.
- New values are committed only on frame boundaries, so a partially updated value is never displayed.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg7_scan_driver.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, scan states and the hex-to-segment encoding for the
// 4-digit common-anode display scanner.
package seg7_pkg;

    localparam int AN_MSB  = 11;
    localparam int AN_LSB  = 8;
    localparam int SEG_MSB = 7;
    localparam int DIGITS  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    // Active-high {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high 7-segment pattern; also used by the
// software-visible test mux.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex7(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Autonomous 4-digit scanner: per-slot anti-ghost guard, PWM brightness and
// tear-free value updates committed only on frame boundaries.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic [3:0]  duty,
    output logic [11:0] digi,
    output logic        frame_done
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [31:0]     GUARD_W  = 32'(GUARD);
    localparam logic [31:0]     POST_LEN = 32'(SCAN_DIV - GUARD);

    scan_state_e      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      stg_value_q, stg_value_d, shd_value_q, shd_value_d;
    logic [3:0]       stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
    logic [3:0]       stg_blank_q, stg_blank_d, shd_blank_q, shd_blank_d;
    logic             pending_q, pending_d;
    logic [11:0]      digi_q, digi_d;
    logic             commit;

    logic [3:0] nibbles [DIGITS];
    logic [6:0] seg_pat;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign nibbles[gi] = shd_value_q[gi*4 +: 4];
    end

    seg7_hex_decode u_dec (
        .nibble_i (nibbles[idx_q]),
        .seg_o    (seg_pat)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        idx_d      = idx_q;
        frame_done = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                idx_d = '0;
                if (enable) begin
                    state_d = ST_SCAN;
                    commit  = 1'b1;
                end
            end
            default: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    idx_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        frame_done = 1'b1;
                        commit     = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
        endcase
    end

    // A load landing on the commit cycle bypasses staging straight to shadow.
    always_comb begin
        stg_value_d = stg_value_q;
        stg_dp_d    = stg_dp_q;
        stg_blank_d = stg_blank_q;
        shd_value_d = shd_value_q;
        shd_dp_d    = shd_dp_q;
        shd_blank_d = shd_blank_q;
        pending_d   = pending_q;
        if (load) begin
            stg_value_d = value;
            stg_dp_d    = dp;
            stg_blank_d = blank;
            pending_d   = 1'b1;
        end
        if (commit) begin
            if (load) begin
                shd_value_d = value;
                shd_dp_d    = dp;
                shd_blank_d = blank;
                pending_d   = 1'b0;
            end else if (pending_q) begin
                shd_value_d = stg_value_q;
                shd_dp_d    = stg_dp_q;
                shd_blank_d = stg_blank_q;
                pending_d   = 1'b0;
            end
        end
    end

    logic [31:0] div_ext;
    logic        lit;

    always_comb begin
        div_ext = 32'(div_q);
        lit     = (((div_ext - GUARD_W) << 4) < ((32'(duty) + 32'd1) * POST_LEN));
        digi_d  = 12'hFFF;
        if (state_q == ST_SCAN && enable && div_ext >= GUARD_W && !shd_blank_q[idx_q]) begin
            digi_d[AN_MSB:AN_LSB] = ~(4'b0001 << idx_q);
            if (lit) begin
                digi_d[SEG_MSB:0] = ~{shd_dp_q[idx_q], seg_pat};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            idx_q       <= '0;
            stg_value_q <= '0;
            stg_dp_q    <= '0;
            stg_blank_q <= '0;
            shd_value_q <= '0;
            shd_dp_q    <= '0;
            shd_blank_q <= '0;
            pending_q   <= 1'b0;
            digi_q      <= 12'hFFF;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            idx_q       <= idx_d;
            stg_value_q <= stg_value_d;
            stg_dp_q    <= stg_dp_d;
            stg_blank_q <= stg_blank_d;
            shd_value_q <= shd_value_d;
            shd_dp_q    <= shd_dp_d;
            shd_blank_q <= shd_blank_d;
            pending_q   <= pending_d;
            digi_q      <= digi_d;
        end
    end

    assign digi = digi_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: a frame-time reference model queues the expected display
// bus per cycle; an independent monitor pops and compares after each edge.
module tb_seg7_scan_driver;

    localparam int SD = 8;
    localparam int GD = 2;
    localparam int FRAME = SD * 4;

    logic        clk = 1'b0;
    logic        rst_n, enable, load;
    logic [15:0] value;
    logic [3:0]  dp, blank, duty;
    logic [11:0] digi;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .blank      (blank),
        .duty       (duty),
        .digi       (digi),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: whether scanning, and cycle position within the frame.
    bit          m_scan = 0;
    int          m_t = 0;
    logic [15:0] m_sv = 0, m_stv = 0;
    logic [3:0]  m_sdp = 0, m_stdp = 0, m_sbl = 0, m_stbl = 0;
    bit          m_pend = 0;
    logic [12:0] exp_q [$];

    function automatic logic [11:0] slot_pattern(int t, logic [15:0] v, logic [3:0] d,
                                                 logic [3:0] b, logic [3:0] du);
        int slot = t / SD;
        int pos  = t % SD;
        logic [11:0] r = 12'hFFF;
        logic [3:0]  an = 4'b1111;
        logic [3:0]  nib = v[slot*4 +: 4];
        if (pos >= GD && !b[slot]) begin
            an[slot] = 1'b0;
            r[11:8] = an;
            if ((pos - GD) * 16 < (int'(du) + 1) * (SD - GD))
                r[7:0] = ~{d[slot], hex_tab[nib]};
        end
        return r;
    endfunction

    initial begin
        logic [11:0] e_digi;
        bit          e_fd, commit;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                e_digi = 12'hFFF;
                m_scan = 0; m_t = 0; m_pend = 0;
                m_sv = 0; m_stv = 0; m_sdp = 0; m_stdp = 0; m_sbl = 0; m_stbl = 0;
            end else begin
                e_digi = (m_scan && enable) ? slot_pattern(m_t, m_sv, m_sdp, m_sbl, duty) : 12'hFFF;
                commit = enable && (!m_scan || m_t == FRAME - 1);
                if (load) begin
                    m_stv = value; m_stdp = dp; m_stbl = blank; m_pend = 1;
                end
                if (commit && m_pend) begin
                    m_sv = m_stv; m_sdp = m_stdp; m_sbl = m_stbl; m_pend = 0;
                end
                if (!enable) begin
                    m_scan = 0; m_t = 0;
                end else if (!m_scan) begin
                    m_scan = 1; m_t = 0;
                end else begin
                    m_t = (m_t + 1) % FRAME;
                end
            end
            e_fd = m_scan && enable && (m_t == FRAME - 1);
            exp_q.push_back({e_digi, e_fd});
        end
    end

    initial begin
        logic [12:0] e;
        forever begin
            @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (digi !== e[12:1]) begin
                    errors++;
                    $display("FAIL digi at %0t: got %03h expected %03h", $time, digi, e[12:1]);
                end
                checks++;
                if (frame_done !== e[0]) begin
                    errors++;
                    $display("FAIL frame_done at %0t: got %0b expected %0b", $time, frame_done, e[0]);
                end
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(logic [15:0] v, logic [3:0] d, logic [3:0] b);
        load = 1'b1; value = v; dp = d; blank = b;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_t(int target);
        bit hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_scan && m_t == target) hit = 1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_position: frame position %0d not reached, now %0d", target, m_t);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; load = 1'b0;
        value = '0; dp = '0; blank = '0; duty = 4'd15;
        @(negedge clk);
        cyc(2);
        rst_n = 1'b1;
        do_load(16'h1234, 4'h0, 4'h0);
        cyc(3 * FRAME);
        wait_t(SD);
        do_load(16'hABCD, 4'h0, 4'h0);
        cyc(70);
        do_load(16'h1111, 4'h0, 4'h0);
        cyc(3);
        do_load(16'h2222, 4'h0, 4'h0);
        cyc(2 * FRAME);
        wait_t(FRAME - 1);
        do_load(16'h5A5A, 4'h0, 4'h0);
        cyc(40);
        do_load(16'h0000, 4'b0001, 4'b1000);
        cyc(70);
        duty = 4'd7;
        cyc(2 * FRAME);
        wait_t(2 * SD);
        enable = 1'b0;
        cyc(3);
        enable = 1'b1;
        cyc(40);
        wait_t(SD + 4);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(40);
        for (int i = 0; i < 3000; i++) begin
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            dp    = 4'($urandom);
            blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 99) == 0) duty = 4'($urandom);
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            rst_n = ($urandom_range(0, 499) != 0);
            @(negedge clk);
        end
        load = 1'b0; rst_n = 1'b1;
        cyc(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
